// File: rtl/neural_train_sched_pkg.sv
// Shared types and constants for the neural predictor training scheduler.
// Row layout: bias in [1:0], weight j (0-based) in [2+3j +: 3], 146 bits total.
package neural_pred_pkg;

  localparam int IDX_W     = 8;
  localparam int N_WT      = 48;
  localparam int WT_BITS   = 3;
  localparam int BIAS_BITS = 2;
  localparam int ROW_W     = BIAS_BITS + N_WT * WT_BITS;

  localparam logic [WT_BITS-1:0]   WT_MAX   = 3'b011;
  localparam logic [WT_BITS-1:0]   WT_MIN   = 3'b100;
  localparam logic [BIAS_BITS-1:0] BIAS_MAX = 2'b01;
  localparam logic [BIAS_BITS-1:0] BIAS_MIN = 2'b10;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dir;
    logic [N_WT-1:0]  rs;
    logic             bias_en;
    logic             wt_en;
  } train_req_t;

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} sched_state_t;

endpackage

// File: rtl/neural_train_sched_if.sv
// Training request channel from the EX-stage update logic into the scheduler.
interface neural_train_sched_if;
  import neural_pred_pkg::*;

  logic             train_valid;
  logic             train_ready;
  logic [IDX_W-1:0] train_idx;
  logic             train_dir;
  logic [N_WT-1:0]  train_rs;
  logic             train_bias_en;
  logic             train_wt_en;

  modport master (
    output train_valid, train_idx, train_dir, train_rs, train_bias_en, train_wt_en,
    input  train_ready
  );

  modport slave (
    input  train_valid, train_idx, train_dir, train_rs, train_bias_en, train_wt_en,
    output train_ready
  );

endinterface

// File: rtl/neural_train_sched_sat_step.sv
// Signed saturating +1/-1 step of a W-bit two's-complement field.
module sat_step #(
  parameter int W = 3
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    result = val;
    if (inc) begin
      if (val != MAX_V) result = val + W'(1);
    end else if (val != MIN_V) begin
      result = val - W'(1);
    end
  end

endmodule

// File: rtl/neural_train_sched.sv
// Queues predictor training requests and runs each as read/step/write-back,
// sharing the single table port with fetch lookups under a starvation guard.
module neural_train_sched
  import neural_pred_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  neural_train_sched_if.slave  train,
  input  logic                 pred_req,
  input  logic [IDX_W-1:0]     pred_idx,
  output logic                 pred_grant,
  output logic                 tbl_en,
  output logic                 tbl_we,
  output logic [IDX_W-1:0]     tbl_addr,
  output logic [ROW_W-1:0]     tbl_wdata,
  input  logic [ROW_W-1:0]     tbl_rdata,
  output logic                 busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   ONE_CNT    = (PW+1)'(1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  sched_state_t     state, next_state;
  train_req_t       fifo_mem [FIFO_DEPTH];
  train_req_t       req_in, head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [SW-1:0]    starve_cnt;
  logic [ROW_W-1:0] row_reg, new_row;
  logic             push, pop, empty, row_load, in_rw, sched_access;

  assign req_in = '{idx: train.train_idx, dir: train.train_dir, rs: train.train_rs,
                    bias_en: train.train_bias_en, wt_en: train.train_wt_en};
  assign head              = fifo_mem[rd_ptr];
  assign empty             = (count == '0);
  assign train.train_ready = (count != FULL_CNT);
  assign push              = train.train_valid && train.train_ready;
  assign busy              = (state != IDLE) || !empty;
  assign tbl_wdata         = row_reg;

  // The scheduler only contends for the port in RD/WR; it yields to fetch until starved.
  assign in_rw        = (state == RD) || (state == WR);
  assign sched_access = in_rw && (!pred_req || (starve_cnt >= STARVE_LIM));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  logic [BIAS_BITS-1:0] bias_step;

  sat_step #(.W(BIAS_BITS)) u_bias_step (
    .val    (tbl_rdata[BIAS_BITS-1:0]),
    .inc    (head.dir),
    .result (bias_step)
  );

  assign new_row[BIAS_BITS-1:0] = head.bias_en ? bias_step : tbl_rdata[BIAS_BITS-1:0];

  for (genvar j = 0; j < N_WT; j++) begin : g_wt
    logic [WT_BITS-1:0] wt_step;

    sat_step #(.W(WT_BITS)) u_wt_step (
      .val    (tbl_rdata[BIAS_BITS + WT_BITS*j +: WT_BITS]),
      .inc    (head.dir == head.rs[j]),
      .result (wt_step)
    );

    assign new_row[BIAS_BITS + WT_BITS*j +: WT_BITS] =
      head.wt_en ? wt_step : tbl_rdata[BIAS_BITS + WT_BITS*j +: WT_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      row_reg    <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (sched_access)          starve_cnt <= '0;
      else if (in_rw && pred_req) starve_cnt <= starve_cnt + SW'(1);
      if (row_load) row_reg <= new_row;
    end
  end

  // An arriving request with nothing queued starts RD directly, giving 3-cycle latency.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    row_load   = 1'b0;
    tbl_en     = 1'b0;
    tbl_we     = 1'b0;
    tbl_addr   = '0;
    pred_grant = pred_req && !sched_access;
    if (pred_grant) begin
      tbl_en   = 1'b1;
      tbl_addr = pred_idx;
    end
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (!head.bias_en && !head.wt_en) pop = 1'b1;
          else next_state = RD;
        end else if (push && (train.train_bias_en || train.train_wt_en)) begin
          next_state = RD;
        end
      end
      RD: begin
        if (sched_access) begin
          tbl_en     = 1'b1;
          tbl_addr   = head.idx;
          next_state = WAIT;
        end
      end
      WAIT: begin
        row_load   = 1'b1;
        next_state = WR;
      end
      WR: begin
        if (sched_access) begin
          tbl_en     = 1'b1;
          tbl_we     = 1'b1;
          tbl_addr   = head.idx;
          pop        = 1'b1;
          next_state = (count > ONE_CNT || push) ? RD : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neural_train_sched.sv
// Directed self-checking bench for neural_train_sched with a behavioural table RAM.
module tb_neural_train_sched;
  import neural_pred_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_req;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_grant, tbl_en, tbl_we, busy;
  logic [IDX_W-1:0] tbl_addr;
  logic [ROW_W-1:0] tbl_wdata, tbl_rdata;

  logic             pl_en;
  logic [IDX_W-1:0] pl_addr;
  logic [ROW_W-1:0] pl_data;
  logic [ROW_W-1:0] mem [256];
  logic [IDX_W-1:0] wlog_addr [64];
  logic [ROW_W-1:0] wlog_data [64];
  int               wcnt = 0;
  int               en_cnt = 0;
  int               wr_idx = 0;
  int               checks = 0;
  int               errors = 0;

  neural_train_sched_if intf ();

  neural_train_sched dut (
    .clk        (clk),
    .rst        (rst),
    .train      (intf.slave),
    .pred_req   (pred_req),
    .pred_idx   (pred_idx),
    .pred_grant (pred_grant),
    .tbl_en     (tbl_en),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .tbl_rdata  (tbl_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single-port table model with one-cycle read latency, plus a log of every write.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (tbl_en) begin
      en_cnt <= en_cnt + 1;
      if (tbl_we) begin
        mem[tbl_addr]   <= tbl_wdata;
        wlog_addr[wcnt] <= tbl_addr;
        wlog_data[wcnt] <= tbl_wdata;
        wcnt            <= wcnt + 1;
      end else begin
        tbl_rdata <= mem[tbl_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [ROW_W-1:0] makeRow(input logic [1:0] b, input logic [2:0] w_even,
                                                input logic [2:0] w_odd);
    logic [ROW_W-1:0] r;
    r      = '0;
    r[1:0] = b;
    for (int j = 0; j < N_WT; j++) r[2 + 3*j +: 3] = (j % 2 == 0) ? w_even : w_odd;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [IDX_W-1:0] a, input logic [ROW_W-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic setReq(input logic [IDX_W-1:0] idx, input logic dir, input logic [N_WT-1:0] rs,
                        input logic ben, input logic wen);
    intf.train_valid   = 1'b1;
    intf.train_idx     = idx;
    intf.train_dir     = dir;
    intf.train_rs      = rs;
    intf.train_bias_en = ben;
    intf.train_wt_en   = wen;
  endtask

  task automatic applyStimulus(input logic [IDX_W-1:0] idx, input logic dir, input logic [N_WT-1:0] rs,
                               input logic ben, input logic wen);
    int n;
    n = 0;
    setReq(idx, dir, rs, ben, wen);
    while (!intf.train_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("accept_ready", intf.train_ready, 1);
    tick();
    intf.train_valid = 1'b0;
  endtask

  task automatic waitWrite(input string tag, input logic [IDX_W-1:0] a, input logic [ROW_W-1:0] d);
    int n;
    n = 0;
    while (wcnt <= wr_idx && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_seen"}, (wcnt > wr_idx), 1);
    if (wcnt > wr_idx) begin
      checkOutput({tag, "_addr"}, wlog_addr[wr_idx], a);
      checkOutput({tag, "_data"}, wlog_data[wr_idx], d);
      wr_idx++;
    end
  endtask

  initial begin
    int en_snap;
    rst                = 1'b1;
    pred_req           = 1'b0;
    pred_idx           = '0;
    pl_en              = 1'b0;
    pl_addr            = '0;
    pl_data            = '0;
    tbl_rdata          = '0;
    intf.train_valid   = 1'b0;
    intf.train_idx     = '0;
    intf.train_dir     = 1'b0;
    intf.train_rs      = '0;
    intf.train_bias_en = 1'b0;
    intf.train_wt_en   = 1'b0;

    preload(8'd5,  makeRow(2'b00, 3'b010, 3'b010));
    preload(8'd9,  makeRow(2'b01, 3'b011, 3'b100));
    preload(8'd12, makeRow(2'b11, 3'b001, 3'b110));
    preload(8'd20, makeRow(2'b00, 3'b000, 3'b000));
    preload(8'd40, makeRow(2'b00, 3'b000, 3'b000));
    preload(8'd41, makeRow(2'b00, 3'b010, 3'b010));
    preload(8'd50, makeRow(2'b00, 3'b000, 3'b000));

    checkOutput("rst_tbl_en", tbl_en, 0);
    checkOutput("rst_tbl_we", tbl_we, 0);
    checkOutput("rst_grant", pred_grant, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", tbl_addr, 0);
    checkOutput("rst_wdata", tbl_wdata, 0);
    checkOutput("rst_ready", intf.train_ready, 1);
    rst = 1'b0;
    tick();

    $display("[TB] basic update with cycle timing");
    setReq(8'd5, 1'b1, '1, 1'b1, 1'b1);
    #1;
    checkOutput("t1_c0_en", tbl_en, 0);
    tick();
    intf.train_valid = 1'b0;
    checkOutput("t1_c1_en", tbl_en, 1);
    checkOutput("t1_c1_we", tbl_we, 0);
    checkOutput("t1_c1_addr", tbl_addr, 5);
    tick();
    checkOutput("t1_c2_en", tbl_en, 0);
    tick();
    checkOutput("t1_c3_en", tbl_en, 1);
    checkOutput("t1_c3_we", tbl_we, 1);
    checkOutput("t1_c3_addr", tbl_addr, 5);
    checkOutput("t1_c3_wdata", tbl_wdata, makeRow(2'b01, 3'b011, 3'b011));
    tick();
    checkOutput("t1_busy", busy, 0);
    waitWrite("t1", 8'd5, makeRow(2'b01, 3'b011, 3'b011));

    $display("[TB] saturation at both limits");
    applyStimulus(8'd9, 1'b1, 48'h5555_5555_5555, 1'b1, 1'b1);
    waitWrite("t2", 8'd9, makeRow(2'b01, 3'b011, 3'b100));

    $display("[TB] field enables");
    applyStimulus(8'd12, 1'b0, '0, 1'b1, 1'b0);
    waitWrite("t3", 8'd12, makeRow(2'b10, 3'b001, 3'b110));
    tick();
    en_snap = en_cnt;
    applyStimulus(8'd13, 1'b1, '1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t3_noop_en", en_cnt - en_snap, 0);
    checkOutput("t3_noop_busy", busy, 0);
    checkOutput("t3_noop_ready", intf.train_ready, 1);

    $display("[TB] contention and starvation guard");
    pred_req = 1'b1;
    pred_idx = 8'd33;
    setReq(8'd20, 1'b1, '1, 1'b1, 1'b1);
    #1;
    checkOutput("t4_idle_grant", pred_grant, 1);
    tick();
    intf.train_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("t4_rd_defer%0d_grant", c), pred_grant, 1);
      checkOutput($sformatf("t4_rd_defer%0d_addr", c), tbl_addr, 33);
      tick();
    end
    checkOutput("t4_rd_force_grant", pred_grant, 0);
    checkOutput("t4_rd_force_en", tbl_en, 1);
    checkOutput("t4_rd_force_we", tbl_we, 0);
    checkOutput("t4_rd_force_addr", tbl_addr, 20);
    tick();
    checkOutput("t4_wait_grant", pred_grant, 1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("t4_wr_defer%0d_grant", c), pred_grant, 1);
      checkOutput($sformatf("t4_wr_defer%0d_we", c), tbl_we, 0);
      tick();
    end
    checkOutput("t4_wr_force_grant", pred_grant, 0);
    checkOutput("t4_wr_force_we", tbl_we, 1);
    checkOutput("t4_wr_force_addr", tbl_addr, 20);
    tick();
    pred_req = 1'b0;
    waitWrite("t4", 8'd20, makeRow(2'b01, 3'b001, 3'b001));

    $display("[TB] backpressure and same-index ordering");
    setReq(8'd40, 1'b1, '1, 1'b1, 1'b1);
    #1;
    checkOutput("t5_c0_ready", intf.train_ready, 1);
    tick();
    setReq(8'd40, 1'b1, '1, 1'b1, 1'b1);
    checkOutput("t5_c1_ready", intf.train_ready, 1);
    tick();
    setReq(8'd41, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t5_c2_ready", intf.train_ready, 0);
    tick();
    checkOutput("t5_c3_ready", intf.train_ready, 0);
    checkOutput("t5_c3_we", tbl_we, 1);
    tick();
    checkOutput("t5_c4_ready", intf.train_ready, 1);
    tick();
    intf.train_valid = 1'b0;
    waitWrite("t5_a", 8'd40, makeRow(2'b01, 3'b001, 3'b001));
    waitWrite("t5_b", 8'd40, makeRow(2'b01, 3'b010, 3'b010));
    waitWrite("t5_c", 8'd41, makeRow(2'b11, 3'b011, 3'b011));
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] reset during WAIT");
    setReq(8'd50, 1'b1, '1, 1'b1, 1'b1);
    tick();
    setReq(8'd50, 1'b1, '1, 1'b1, 1'b1);
    tick();
    intf.train_valid = 1'b0;
    checkOutput("t6_full_ready", intf.train_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_busy", busy, 0);
    checkOutput("t6_async_ready", intf.train_ready, 1);
    checkOutput("t6_async_en", tbl_en, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t6_no_write", wcnt, wr_idx);
    checkOutput("t6_row_kept", mem[50], makeRow(2'b00, 3'b000, 3'b000));
    checkOutput("t6_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
